// File: rtl/gcm_ct_collector.sv
// gcm_ct_collector: FWFT FIFO that collects AES-GCM ciphertext blocks with message first/last/index tags
module gcm_ct_collector #(
  parameter int DEPTH     = 4,
  parameter int BYPASS_W  = 289,
  parameter int BYTE_SWAP = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_ct_valid,
  input  logic [127:0]              i_cipher_text,
  input  logic [BYPASS_W-1:0]       i_bypass_text,
  input  logic                      i_last,
  input  logic                      i_clear,
  input  logic                      i_ready,
  output logic                      o_valid,
  output logic [127:0]              o_data,
  output logic [BYPASS_W-1:0]       o_bypass,
  output logic                      o_first,
  output logic                      o_last,
  output logic [7:0]                o_blk_idx,
  output logic [$clog2(DEPTH):0]    o_level,
  output logic                      o_full,
  output logic                      o_empty,
  output logic                      o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  typedef enum logic {IDLE, IN_MSG} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic [7:0] idx_q, idx_d;
  logic ovf_q, ovf_d;
  logic [127:0] data_mem [DEPTH];
  logic [BYPASS_W-1:0] byp_mem [DEPTH];
  logic first_mem [DEPTH];
  logic last_mem [DEPTH];
  logic [7:0] idx_mem [DEPTH];
  logic [127:0] ct_in;
  logic wr, rd, drop, last_seen;
  genvar n;
  generate
    if (BYTE_SWAP != 0) begin : g_swap
      for (n = 0; n < 16; n++) begin : g_byte
        assign ct_in[8*n +: 8] = i_cipher_text[8*(15-n) +: 8];
      end
    end else begin : g_pass
      assign ct_in = i_cipher_text;
    end
  endgenerate
  assign o_empty   = level_q == '0;
  assign o_full    = level_q == FULL_LVL;
  assign o_valid   = !o_empty;
  assign rd        = o_valid && i_ready;
  assign wr        = i_ct_valid && (!o_full || rd);
  assign drop      = i_ct_valid && !wr;
  assign last_seen = i_ct_valid && i_last;
  // Next-state: clear wins over everything; a last block (kept or dropped) ends the message
  always_comb begin
    state_d  = (i_clear || last_seen) ? IDLE : wr ? IN_MSG : state_q;
    idx_d    = (i_clear || last_seen) ? '0 : wr ? idx_q + 8'd1 : idx_q;
    wr_ptr_d = i_clear ? '0 : wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = i_clear ? '0 : rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = i_clear ? '0 : level_q + (AW+1)'(wr) - (AW+1)'(rd);
    ovf_d    = !i_clear && (ovf_q || drop);
  end
  // Control state register, asynchronously cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end
  // Entry storage; contents need no reset since head outputs are masked while empty
  always_ff @(posedge clk) begin
    if (wr && !i_clear) begin
      data_mem[wr_ptr_q]  <= ct_in;
      byp_mem[wr_ptr_q]   <= i_bypass_text;
      first_mem[wr_ptr_q] <= state_q == IDLE;
      last_mem[wr_ptr_q]  <= i_last;
      idx_mem[wr_ptr_q]   <= idx_q;
    end
  end
  assign o_data     = o_valid ? data_mem[rd_ptr_q] : '0;
  assign o_bypass   = o_valid ? byp_mem[rd_ptr_q] : '0;
  assign o_first    = o_valid && first_mem[rd_ptr_q];
  assign o_last     = o_valid && last_mem[rd_ptr_q];
  assign o_blk_idx  = o_valid ? idx_mem[rd_ptr_q] : '0;
  assign o_level    = level_q;
  assign o_overflow = ovf_q;
endmodule

// File: tb/tb_gcm_ct_collector.sv
// tb_gcm_ct_collector: directed stimulus with a queue-based reference model checked every cycle
module tb_gcm_ct_collector;
  localparam int DEPTH = 4;
  localparam int BW = 289;
  logic clk, reset, i_ct_valid, i_last, i_clear, i_ready;
  logic [127:0] i_cipher_text;
  logic [BW-1:0] i_bypass_text;
  logic o_valid, o_first, o_last, o_full, o_empty, o_overflow;
  logic [127:0] o_data;
  logic [BW-1:0] o_bypass;
  logic [7:0] o_blk_idx;
  logic [2:0] o_level;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic [127:0] d;
    logic [BW-1:0] b;
    logic f;
    logic l;
    logic [7:0] x;
  } ent_t;
  ent_t q[$];
  bit m_in, m_ovf;
  int m_cnt;
  gcm_ct_collector #(.DEPTH(DEPTH), .BYPASS_W(BW), .BYTE_SWAP(1)) dut (
    .clk(clk), .reset(reset), .i_ct_valid(i_ct_valid), .i_cipher_text(i_cipher_text),
    .i_bypass_text(i_bypass_text), .i_last(i_last), .i_clear(i_clear), .i_ready(i_ready),
    .o_valid(o_valid), .o_data(o_data), .o_bypass(o_bypass), .o_first(o_first),
    .o_last(o_last), .o_blk_idx(o_blk_idx), .o_level(o_level), .o_full(o_full),
    .o_empty(o_empty), .o_overflow(o_overflow));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Reference model: a queue of tagged entries updated at each edge
  always @(posedge clk or negedge reset) begin
    ent_t e;
    bit rd, wr;
    if (!reset || i_clear) begin
      q.delete();
      m_in = 0;
      m_cnt = 0;
      m_ovf = 0;
    end else begin
      rd = q.size() > 0 && i_ready;
      wr = i_ct_valid && (q.size() < DEPTH || rd);
      if (rd) void'(q.pop_front());
      if (wr) begin
        e.d = {<<8{i_cipher_text}};
        e.b = i_bypass_text;
        e.f = !m_in;
        e.l = i_last;
        e.x = m_cnt[7:0];
        q.push_back(e);
      end else if (i_ct_valid) m_ovf = 1;
      if (i_ct_valid && i_last) begin
        m_cnt = 0;
        m_in = 0;
      end else if (wr) begin
        m_cnt = (m_cnt + 1) % 256;
        m_in = 1;
      end
    end
  end
  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    chk("valid", o_valid, q.size() > 0);
    chk("level", o_level, BW'(q.size()));
    chk("full", o_full, q.size() == DEPTH);
    chk("empty", o_empty, q.size() == 0);
    chk("overflow", o_overflow, m_ovf);
    chk("data", o_data, q.size() > 0 ? q[0].d : '0);
    chk("bypass", o_bypass, q.size() > 0 ? q[0].b : '0);
    chk("first", o_first, q.size() > 0 ? q[0].f : 1'b0);
    chk("last", o_last, q.size() > 0 ? q[0].l : 1'b0);
    chk("blk_idx", o_blk_idx, q.size() > 0 ? q[0].x : 8'd0);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [127:0] d, input logic l);
    logic [BW-1:0] b;
    b = '0;
    for (int k = 0; k < 10; k++) b = {b[BW-33:0], 32'($urandom)};
    i_ct_valid = 1;
    i_cipher_text = d;
    i_bypass_text = b;
    i_last = l;
    tick();
    i_ct_valid = 0;
    i_last = 0;
  endtask
  initial begin
    reset = 0;
    i_ct_valid = 0;
    i_last = 0;
    i_clear = 0;
    i_ready = 0;
    i_cipher_text = '0;
    i_bypass_text = '0;
    tick();
    tick();
    chk("rst_empty", o_empty, 1'b1);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_level", o_level, 3'd0);
    reset = 1;
    tick();
    send(128'h00112233445566778899AABBCCDDEEFF, 1);
    chk("single_valid", o_valid, 1'b1);
    chk("single_data", o_data, 128'hFFEEDDCCBBAA99887766554433221100);
    chk("single_first", o_first, 1'b1);
    chk("single_last", o_last, 1'b1);
    chk("single_idx", o_blk_idx, 8'd0);
    i_ready = 1;
    tick();
    for (int b = 0; b < 3; b++) begin
      send(128'h1000 + 128'(b), b == 2);
      chk("msg3_idx", o_blk_idx, 8'(b));
      chk("msg3_first", o_first, b == 0);
      chk("msg3_last", o_last, b == 2);
      tick();
    end
    i_ready = 0;
    for (int k = 0; k < 6; k++) send(128'h2000 + 128'(k), k == 5);
    chk("ovf_level", o_level, 3'd4);
    chk("ovf_full", o_full, 1'b1);
    chk("ovf_flag", o_overflow, 1'b1);
    chk("ovf_head", o_data, {<<8{128'h2000}});
    i_ready = 1;
    for (int k = 0; k < 10 && !o_empty; k++) tick();
    chk("ovf_drained", o_empty, 1'b1);
    send(128'h3000, 0);
    chk("after_drop_first", o_first, 1'b1);
    chk("after_drop_idx", o_blk_idx, 8'd0);
    tick();
    i_clear = 1;
    tick();
    i_clear = 0;
    i_ready = 0;
    for (int k = 0; k < 4; k++) send(128'h4000 + 128'(k), 0);
    i_ready = 1;
    send(128'h4004, 0);
    chk("fullrw_level", o_level, 3'd4);
    chk("fullrw_ovf", o_overflow, 1'b0);
    chk("fullrw_full", o_full, 1'b1);
    i_clear = 1;
    tick();
    i_clear = 0;
    i_ready = 0;
    for (int k = 0; k < 3; k++) send(128'h5000 + 128'(k), 0);
    i_clear = 1;
    send(128'h5003, 0);
    i_clear = 0;
    chk("clr_level", o_level, 3'd0);
    chk("clr_valid", o_valid, 1'b0);
    chk("clr_ovf", o_overflow, 1'b0);
    send(128'h5004, 0);
    chk("clr_first", o_first, 1'b1);
    chk("clr_idx", o_blk_idx, 8'd0);
    i_clear = 1;
    tick();
    i_clear = 0;
    i_ready = 1;
    for (int k = 0; k < 256; k++) send(128'h6000 + 128'(k), 0);
    chk("wrap_255", o_blk_idx, 8'd255);
    send(128'h6100, 0);
    chk("wrap_0", o_blk_idx, 8'd0);
    chk("wrap_first", o_first, 1'b0);
    send(128'h6101, 1);
    chk("wrap_last_idx", o_blk_idx, 8'd1);
    chk("wrap_last", o_last, 1'b1);
    tick();
    i_ready = 0;
    send(128'h7000, 0);
    send(128'h7001, 0);
    #2;
    reset = 0;
    #1;
    chk("arst_valid", o_valid, 1'b0);
    chk("arst_data", o_data, '0);
    chk("arst_level", o_level, 3'd0);
    chk("arst_empty", o_empty, 1'b1);
    chk("arst_idx", o_blk_idx, 8'd0);
    reset = 1;
    tick();
    send(128'h7002, 1);
    chk("arst_next_first", o_first, 1'b1);
    chk("arst_next_idx", o_blk_idx, 8'd0);
    chk("arst_next_level", o_level, 3'd1);
    i_ready = 1;
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
